// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller and its pedestrian button front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } ped_state_e;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/button_debounce.sv
// Synchroniser chain plus counter-based debouncer; emits a strobe on the edge where the
// debounced level is about to go from released to pressed.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic press_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic                   db;
  logic [CNT_W-1:0]       cnt;
  logic                   flip;

  assign sync       = sync_chain[SYNC_STAGES-1];
  assign flip       = (sync != db) && (cnt == CNT_LAST);
  assign press_rise = flip && sync;

  // Any sample that agrees with db restarts the count, so short glitches never flip it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
      db         <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], button_raw};
      if (flip) begin
        db  <= sync;
        cnt <= '0;
      end else if (sync == db) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian button conditioner: debounce, press pulse, held request FSM with rearm.
// Define PED_PRESS_COUNT_EN to add the saturating press_count output.
module ped_button_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  input  logic walk,
  output logic ped_request,
  output logic press_pulse
`ifdef PED_PRESS_COUNT_EN
  ,
  output logic [PRESS_CNT_W-1:0] press_count
`endif
);

  logic       press_rise;
  ped_state_e state;
  ped_state_e state_next;
  logic       rearm;
  logic       rearm_next;

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .button_raw(button_raw),
    .press_rise(press_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse <= 1'b0;
      state       <= IDLE;
      rearm       <= 1'b0;
    end else begin
      press_pulse <= press_rise;
      state       <= state_next;
      rearm       <= rearm_next;
    end
  end

  // A press seen while walk is active is remembered and re-requested once walk ends.
  always_comb begin
    state_next = state;
    rearm_next = rearm;
    case (state)
      IDLE: begin
        if (press_pulse) state_next = PENDING;
      end
      PENDING: begin
        if (walk) state_next = SERVING;
      end
      SERVING: begin
        if (!walk) begin
          state_next = (rearm || press_pulse) ? PENDING : IDLE;
          rearm_next = 1'b0;
        end else if (press_pulse) begin
          rearm_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        rearm_next = 1'b0;
      end
    endcase
  end

  assign ped_request = (state == PENDING);

`ifdef PED_PRESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      press_count <= '0;
    end else if (press_pulse && (press_count != '1)) begin
      press_count <= press_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Table-driven bench for ped_button_conditioner with a scoreboard of expected outputs;
// also checks press_count when PED_PRESS_COUNT_EN is defined.
module tb_ped_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic button_raw;
  logic walk;
  logic ped_request;
  logic press_pulse;
`ifdef PED_PRESS_COUNT_EN
  logic [7:0] press_count;
`endif

  typedef struct {
    logic  raw;
    logic  walk;
    logic  rst;
    logic  exp_pulse;
    logic  exp_req;
    string name;
  } vec_t;

  typedef struct {
    logic  pulse;
    logic  req;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses;

  always #5 clk = ~clk;

  ped_button_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_raw (button_raw),
    .walk       (walk),
    .ped_request(ped_request),
    .press_pulse(press_pulse)
`ifdef PED_PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

  task automatic addRun(input logic r, input logic w, input logic rs, input int n,
                        input logic p, input logic q, input string nm);
    for (int i = 0; i < n; i++) vecs.push_back('{r, w, rs, p, q, nm});
  endtask

  task automatic checkOutput();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_empty: no expected entry for vector %0d", n_vec);
    end else begin
      e = sb.pop_front();
      if (press_pulse !== e.pulse || ped_request !== e.req) begin
        n_err++;
        $display("[TB] FAIL %s: vector %0d press_pulse=%0b ped_request=%0b, expected %0b/%0b",
                 e.name, n_vec, press_pulse, ped_request, e.pulse, e.req);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    button_raw = v.raw;
    walk       = v.walk;
    rst        = v.rst;
    sb.push_back('{v.exp_pulse, v.exp_req, v.name});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runTable();
    foreach (vecs[i]) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  task automatic checkValue(input string nm, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, actual, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    button_raw = 1'b0;
    walk       = 1'b0;

    // raw, walk, rst, count, exp press_pulse, exp ped_request
    addRun(0, 0, 1, 2, 0, 0, "reset");
    addRun(1, 0, 0, 5, 0, 0, "press_wait");
    addRun(1, 0, 0, 1, 1, 0, "press_pulse");
    addRun(1, 0, 0, 2, 0, 1, "press_req");
    addRun(0, 0, 0, 6, 0, 1, "release_hold");
    addRun(0, 1, 0, 2, 0, 0, "serve_walk");
    addRun(0, 0, 0, 2, 0, 0, "serve_idle");
    addRun(0, 1, 0, 2, 0, 0, "idle_walk");
    addRun(0, 0, 0, 1, 0, 0, "idle_walk_off");
    addRun(1, 0, 0, 3, 0, 0, "glitch_hi");
    addRun(0, 0, 0, 6, 0, 0, "glitch_lo");
    addRun(1, 0, 0, 1, 0, 0, "bounce");
    addRun(0, 0, 0, 1, 0, 0, "bounce");
    addRun(1, 0, 0, 1, 0, 0, "bounce");
    addRun(0, 0, 0, 1, 0, 0, "bounce");
    addRun(1, 0, 0, 5, 0, 0, "bounce_settle");
    addRun(1, 0, 0, 1, 1, 0, "bounce_pulse");
    addRun(1, 0, 0, 2, 0, 1, "bounce_req");
    addRun(0, 0, 0, 6, 0, 1, "release2");
    addRun(0, 1, 0, 1, 0, 0, "rearm_serve");
    addRun(1, 1, 0, 5, 0, 0, "rearm_wait");
    addRun(1, 1, 0, 1, 1, 0, "rearm_pulse");
    addRun(1, 1, 0, 2, 0, 0, "rearm_hold");
    addRun(1, 0, 0, 2, 0, 1, "rearm_req");
    runTable();

`ifdef PED_PRESS_COUNT_EN
    checkValue("count_before_reset", int'(press_count), 3);
`endif

    addRun(0, 0, 1, 1, 0, 0, "mid_reset");
    addRun(0, 0, 0, 3, 0, 0, "after_reset");
    runTable();

`ifdef PED_PRESS_COUNT_EN
    checkValue("count_after_reset", int'(press_count), 0);
`endif

    // 260 clean presses: the pulse count must match and the counter must saturate.
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      for (int c = 0; c < 10; c++) begin
        button_raw = (c < 5);
        @(posedge clk);
        #1;
        if (press_pulse === 1'b1) pulses++;
      end
    end
    button_raw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (press_pulse === 1'b1) pulses++;
    end
    checkValue("storm_pulses", pulses, 260);
    checkValue("storm_request", int'(ped_request), 1);
`ifdef PED_PRESS_COUNT_EN
    checkValue("count_saturated", int'(press_count), 255);
`endif

    checkValue("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
